// File: rtl/lgn_pkg.sv
// Shared definitions for the logic-gate-network classifier front end.
// Holds network sizing, counter widths and the packer state encoding.
package lgn_pkg;

  localparam int INPUTS     = 784;
  localparam int PIXEL_BITS = 8;

  localparam int BIT_CNT_W  = $clog2(PIXEL_BITS);
  localparam int PIX_CNT_W  = $clog2(INPUTS);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } pixel_packer_state_t;

  function automatic logic binarise(input logic [PIXEL_BITS-1:0] pix,
                                    input logic [PIXEL_BITS-1:0] thr);
    return (pix >= thr);
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Thresholds each accepted pixel and packs eight binary pixels MSB-first
// into a byte, strobing byte_we for one cycle when a byte completes.
module bit_packer
  import lgn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [PIXEL_BITS-1:0] pix_data,
  input  logic [PIXEL_BITS-1:0] threshold,
  output logic [PIXEL_BITS-1:0] byte_out,
  output logic                  byte_we
);

  logic [PIXEL_BITS-2:0] shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  pix_bit;
  logic [PIXEL_BITS-1:0] next_byte;

  assign pix_bit   = binarise(pix_data, threshold);
  assign next_byte = {shift_reg, pix_bit};

  // Clear wins over a simultaneous shift so a discarded group never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_out  <= '0;
      byte_we   <= 1'b0;
    end else begin
      byte_we <= 1'b0;
      if (clear) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= next_byte[PIXEL_BITS-2:0];
        if (bit_cnt == BIT_CNT_W'(PIXEL_BITS - 1)) begin
          byte_out <= next_byte;
          byte_we  <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Classifier front end: frames pixels, feeds packed bytes to the network
// input register, then stalls input while the network output settles.
module pixel_packer
  import lgn_pkg::*;
#(
  parameter int PIXELS        = INPUTS,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_BITS-1:0] threshold,
  input  logic [PIXEL_BITS-1:0] pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_last,
  output logic                  pix_ready,
  output logic [PIXEL_BITS-1:0] byte_out,
  output logic                  byte_we,
  output logic                  frame_done,
  output logic                  result_valid,
  output logic                  frame_error
);

  localparam int PW = $clog2(PIXELS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0] LAST_IDX    = PW'(PIXELS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  pixel_packer_state_t state, next_state;
  logic [PW-1:0] pix_cnt;
  logic [SW-1:0] settle_cnt;
  logic          accept;
  logic          at_last_idx;
  logic          early_last;
  logic          misaligned;

  assign accept      = pix_valid & pix_ready;
  assign at_last_idx = (pix_cnt == LAST_IDX);
  assign early_last  = accept & pix_last & ~at_last_idx;
  assign misaligned  = pix_last ^ at_last_idx;

  bit_packer u_bit_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (early_last),
    .shift_en  (accept),
    .pix_data  (pix_data),
    .threshold (threshold),
    .byte_out  (byte_out),
    .byte_we   (byte_we)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (accept && at_last_idx) next_state = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = DONE;
      DONE:    if (accept) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  always_comb begin
    pix_ready    = (state != SETTLE);
    result_valid = (state == DONE);
  end

  // An early pix_last restarts the frame at pixel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      if (accept) begin
        if (at_last_idx || pix_last) pix_cnt <= '0;
        else                         pix_cnt <= pix_cnt + PW'(1);
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
      else                 settle_cnt <= '0;
    end
  end

  // The first pixel accepted in DONE opens a new frame, so the error flag
  // restarts from that pixel's own alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done <= accept & at_last_idx;
      if (accept) begin
        if (state == DONE)   frame_error <= misaligned;
        else if (misaligned) frame_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Directed self-checking bench for pixel_packer with hand-computed expectations.
module tb_pixel_packer;
  import lgn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic [7:0] pix_data = 8'd0;
  logic       pix_valid = 1'b0;
  logic       pix_last = 1'b0;
  logic       pix_ready;
  logic [7:0] byte_out;
  logic       byte_we;
  logic       frame_done;
  logic       result_valid;
  logic       frame_error;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int dones = 0;
  bit hs = 1'b0;
  logic [7:0] bytes_q[$];

  pixel_packer #(.PIXELS(784), .SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .threshold    (threshold),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .byte_out     (byte_out),
    .byte_we      (byte_we),
    .frame_done   (frame_done),
    .result_valid (result_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    hs = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    if (byte_we) begin
      strobes++;
      bytes_q.push_back(byte_out);
    end
    if (frame_done) dones++;
  endtask

  task automatic clear_stats();
    strobes = 0;
    dones = 0;
    bytes_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    pix_data = 8'd0;
    cycle();
    rst = 1'b0;
    clear_stats();
  endtask

  function automatic logic [7:0] pattern(input int mode, input int i);
    case (mode)
      0:       return (i % 2 == 0) ? 8'hFF : 8'h00;
      1:       return 8'hFF;
      2:       return (i % 8 == 0) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic send_pixels(input int count, input int last_at, input int mode, input bit hold);
    for (int i = 0; i < count; i++) begin
      pix_valid = 1'b1;
      pix_data = pattern(mode, i);
      pix_last = (i == last_at);
      cycle();
    end
    pix_last = 1'b0;
    if (hold) pix_data = 8'hFF;
    else pix_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'hFF;
    cycle();
    rst = 1'b0;
    pix_valid = 1'b0;
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_pix_ready: got %b expected 1", pix_ready); end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte_out: got %h expected 00", byte_out); end
    checks++; if (byte_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_byte_we: got %b expected 0", byte_we); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_result_valid: got %b expected 0", result_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_error: got %b expected 0", frame_error); end
    clear_stats();
  endtask

  task automatic test_alternating();
    int bad;
    do_reset();
    threshold = 8'd128;
    send_pixels(784, 783, 0, 1'b1);
    bad = 0;
    foreach (bytes_q[k]) if (bytes_q[k] !== 8'hAA) bad++;
    checks++; if (strobes !== 98) begin errors++; $display("[TB] FAIL alt_strobes: got %0d expected 98", strobes); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL alt_bytes: %0d bytes differ from AA, expected 0", bad); end
    checks++; if (frame_done !== 1'b1 || byte_we !== 1'b1) begin errors++; $display("[TB] FAIL alt_done_with_last_byte: done=%b we=%b expected 1 1", frame_done, byte_we); end
    checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL alt_done_count: got %0d expected 1", dones); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL alt_frame_error: got %b expected 0", frame_error); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL settle_ready_t1: got %b expected 0", pix_ready); end
    for (int k = 2; k <= 4; k++) begin
      cycle();
      checks++; if (pix_ready !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL settle_t%0d: ready=%b rv=%b expected 0 0", k, pix_ready, result_valid); end
    end
    cycle();
    pix_valid = 1'b0;
    checks++; if (result_valid !== 1'b1 || pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL settle_t5: rv=%b ready=%b expected 1 1", result_valid, pix_ready); end
    checks++; if (strobes !== 98) begin errors++; $display("[TB] FAIL settle_no_accept: strobes %0d expected 98", strobes); end
    checks++; if (byte_out !== 8'hAA) begin errors++; $display("[TB] FAIL byte_out_hold: got %h expected AA", byte_out); end
  endtask

  task automatic test_gaps();
    int accepted = 0;
    int guard = 0;
    bit valid;
    bit exp_we;
    logic [7:0] exp_byte;
    do_reset();
    while (accepted < 32 && guard < 400) begin
      valid = ($urandom_range(0, 2) != 0);
      pix_valid = valid;
      pix_last = 1'b0;
      threshold = ((accepted / 8) % 2 == 0) ? 8'd100 : 8'd101;
      pix_data = valid ? 8'd100 : 8'hFF;
      cycle();
      if (hs) accepted++;
      exp_we = hs && (accepted % 8 == 0);
      checks++; if (byte_we !== exp_we) begin errors++; $display("[TB] FAIL gap_strobe@%0d: got %b expected %b", accepted, byte_we, exp_we); end
      if (exp_we) begin
        exp_byte = (((accepted / 8) - 1) % 2 == 0) ? 8'hFF : 8'h00;
        checks++; if (byte_out !== exp_byte) begin errors++; $display("[TB] FAIL gap_byte@%0d: got %h expected %h", accepted, byte_out, exp_byte); end
      end
      guard++;
    end
    pix_valid = 1'b0;
    checks++; if (accepted !== 32) begin errors++; $display("[TB] FAIL gap_timeout: accepted %0d expected 32", accepted); end
  endtask

  task automatic test_early_last();
    int bad;
    logic [7:0] first;
    do_reset();
    threshold = 8'd128;
    send_pixels(13, 12, 3, 1'b0);
    first = (bytes_q.size() > 0) ? bytes_q[0] : 8'h5A;
    checks++; if (strobes !== 1) begin errors++; $display("[TB] FAIL early_strobes: got %0d expected 1", strobes); end
    checks++; if (first !== 8'h00) begin errors++; $display("[TB] FAIL early_first_byte: got %h expected 00", first); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("[TB] FAIL early_frame_error: got %b expected 1", frame_error); end
    checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL early_no_done: got %0d expected 0", dones); end
    clear_stats();
    send_pixels(784, 783, 2, 1'b0);
    bad = 0;
    foreach (bytes_q[k]) if (bytes_q[k] !== 8'h80) bad++;
    checks++; if (strobes !== 98) begin errors++; $display("[TB] FAIL early_next_strobes: got %0d expected 98", strobes); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL early_next_bytes: %0d bytes differ from 80, expected 0", bad); end
    checks++; if (dones !== 1) begin errors++; $display("[TB] FAIL early_next_done: got %0d expected 1", dones); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("[TB] FAIL early_sticky: got %b expected 1", frame_error); end
    wait_cycles(4);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL early_result_valid: got %b expected 1", result_valid); end
  endtask

  task automatic test_no_last();
    do_reset();
    threshold = 8'd0;
    send_pixels(784, -1, 3, 1'b0);
    checks++; if (strobes !== 98 || dones !== 1) begin errors++; $display("[TB] FAIL nolast_complete: strobes=%0d dones=%0d expected 98 1", strobes, dones); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("[TB] FAIL nolast_error: got %b expected 1", frame_error); end
    wait_cycles(4);
    checks++; if (result_valid !== 1'b1 || frame_error !== 1'b1) begin errors++; $display("[TB] FAIL nolast_done: rv=%b err=%b expected 1 1", result_valid, frame_error); end
    pix_valid = 1'b1;
    pix_data = 8'h00;
    pix_last = 1'b0;
    cycle();
    pix_valid = 1'b0;
    checks++; if (result_valid !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("[TB] FAIL nolast_clear: rv=%b err=%b expected 0 0", result_valid, frame_error); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL nolast_ready: got %b expected 1", pix_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    threshold = 8'd128;
    send_pixels(400, -1, 0, 1'b0);
    checks++; if (strobes !== 50) begin errors++; $display("[TB] FAIL mid_pre_strobes: got %0d expected 50", strobes); end
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'hFF;
    cycle();
    rst = 1'b0;
    pix_valid = 1'b0;
    checks++; if (byte_we !== 1'b0 || byte_out !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_byte: we=%b out=%h expected 0 00", byte_we, byte_out); end
    checks++; if (pix_ready !== 1'b1 || frame_done !== 1'b0 || result_valid !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_flags: rdy=%b done=%b rv=%b err=%b expected 1 0 0 0", pix_ready, frame_done, result_valid, frame_error); end
    clear_stats();
    send_pixels(784, 783, 0, 1'b0);
    checks++; if (strobes !== 98 || dones !== 1) begin errors++; $display("[TB] FAIL mid_frame1: strobes=%0d dones=%0d expected 98 1", strobes, dones); end
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (pix_ready !== 1'b1 || result_valid !== 1'b0 || byte_we !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL settle_rst: rdy=%b rv=%b we=%b done=%b expected 1 0 0 0", pix_ready, result_valid, byte_we, frame_done); end
    wait_cycles(6);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL settle_rst_stays_fill: got %b expected 0", result_valid); end
    clear_stats();
    send_pixels(784, 783, 0, 1'b0);
    checks++; if (strobes !== 98 || dones !== 1) begin errors++; $display("[TB] FAIL mid_frame2: strobes=%0d dones=%0d expected 98 1", strobes, dones); end
    wait_cycles(4);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_frame2_rv: got %b expected 1", result_valid); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_gaps();
    test_early_last();
    test_no_last();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
